// File: rtl/sm_port_arbiter.sv
// sm_port_arbiter: shares the single-ported system memory between the pipeline
// MEM stage (P) and the host/initialisation loader (H).
//
// Handshake: a requester raises req with we/addr/wdata and holds all of them
// stable until it sees gnt high in the same cycle; gnt high means the access
// was accepted that cycle. Read responses come back as a one-cycle rvalid
// pulse with rdata, two cycles after the grant, in grant order, with no
// backpressure. err is a one-cycle pulse one cycle after a bad-address grant.
module sm_port_arbiter #(
    parameter int SM_DEPTH = 128,
    parameter int ADDR_W   = $clog2(SM_DEPTH << 2)
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              mem_init,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [31:0]       p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [31:0]       p_rdata,
    output logic              p_err,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [31:0]       h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [31:0]       h_rdata,
    output logic              h_err,
    output logic [ADDR_W-1:0] sm_writeAddr,
    output logic [31:0]       sm_writeData,
    output logic              sm_writeEn,
    output logic [ADDR_W-1:0] sm_readAddr,
    output logic              sm_readEn,
    input  logic [31:0]       sm_readData,
    output logic              stall_pipe,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_INIT  = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_U = 32'(SM_DEPTH);

    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;     // 1 = H won the last grant
    logic        rd_pend_q, rd_pend_d;       // read in its memory data cycle
    logic        rd_owner_q, rd_owner_d;     // 1 = that read belongs to H
    logic        rd_bad_q, rd_bad_d;         // that read had a bad address
    logic        p_rvalid_q, p_rvalid_d;
    logic        h_rvalid_q, h_rvalid_d;
    logic [31:0] p_rdata_q, p_rdata_d;
    logic [31:0] h_rdata_q, h_rdata_d;
    logic        p_err_q, p_err_d;
    logic        h_err_q, h_err_d;

    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_bad;
    logic              rd_gnt;

    // Misaligned or beyond the last word: granted, but never reaches memory.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (32'(a[ADDR_W-1:2]) >= DEPTH_U);
    endfunction

    // Grant selection: round-robin in RUN, host only in INIT, nobody in DRAIN or reset.
    always_comb begin
        p_gnt = 1'b0;
        h_gnt = 1'b0;
        if (reset_n) begin
            case (state_q)
                ST_RUN: begin
                    if (p_req && h_req) begin
                        p_gnt = last_gnt_q;
                        h_gnt = !last_gnt_q;
                    end else begin
                        p_gnt = p_req;
                        h_gnt = h_req;
                    end
                end
                ST_INIT: h_gnt = h_req;
                default: ;
            endcase
        end
    end

    // Route the granted access onto the memory strobes in the same cycle.
    always_comb begin
        any_gnt      = p_gnt || h_gnt;
        sel_we       = h_gnt ? h_we : p_we;
        sel_addr     = h_gnt ? h_addr : p_addr;
        sel_wdata    = h_gnt ? h_wdata : p_wdata;
        sel_bad      = addr_bad(sel_addr);
        rd_gnt       = any_gnt && !sel_we;
        sm_writeEn   = any_gnt && sel_we && !sel_bad;
        sm_readEn    = rd_gnt && !sel_bad;
        sm_writeAddr = sm_writeEn ? sel_addr : '0;
        sm_writeData = sm_writeEn ? sel_wdata : '0;
        sm_readAddr  = sm_readEn ? sel_addr : '0;
    end

    // Next state of the FSM, the read pipeline and the response registers.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        if (p_gnt) last_gnt_d = 1'b0;
        if (h_gnt) last_gnt_d = 1'b1;

        rd_pend_d  = rd_gnt;
        rd_owner_d = h_gnt;
        rd_bad_d   = sel_bad;

        p_err_d    = p_gnt && sel_bad;
        h_err_d    = h_gnt && sel_bad;

        p_rvalid_d = rd_pend_q && !rd_owner_q;
        h_rvalid_d = rd_pend_q && rd_owner_q;
        p_rdata_d  = p_rdata_q;
        h_rdata_d  = h_rdata_q;
        if (p_rvalid_d) p_rdata_d = rd_bad_q ? 32'd0 : sm_readData;
        if (h_rvalid_d) h_rdata_d = rd_bad_q ? 32'd0 : sm_readData;

        case (state_q)
            ST_RUN: begin
                // A read granted now still needs its data cycle before H owns memory.
                if (mem_init) state_d = rd_gnt ? ST_DRAIN : ST_INIT;
            end
            ST_DRAIN: begin
                // The drained read is in its data cycle now; nothing is left after this edge.
                state_d = mem_init ? ST_INIT : ST_RUN;
            end
            ST_INIT: begin
                if (!mem_init) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers; reset discards any read in flight.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            last_gnt_q <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rd_bad_q   <= 1'b0;
            p_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
            p_rdata_q  <= 32'd0;
            h_rdata_q  <= 32'd0;
            p_err_q    <= 1'b0;
            h_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            rd_bad_q   <= rd_bad_d;
            p_rvalid_q <= p_rvalid_d;
            h_rvalid_q <= h_rvalid_d;
            p_rdata_q  <= p_rdata_d;
            h_rdata_q  <= h_rdata_d;
            p_err_q    <= p_err_d;
            h_err_q    <= h_err_d;
        end
    end

    assign p_rvalid   = p_rvalid_q;
    assign h_rvalid   = h_rvalid_q;
    assign p_rdata    = p_rdata_q;
    assign h_rdata    = h_rdata_q;
    assign p_err      = p_err_q;
    assign h_err      = h_err_q;
    assign stall_pipe = (state_q != ST_RUN);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sm_port_arbiter.sv
// Bench for sm_port_arbiter: directed scenarios with literal expectations,
// then random traffic, all watched by a per-cycle reference model.
module tb_sm_port_arbiter;

    localparam int SM_DEPTH = 128;
    localparam int AW       = 10;
    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_INIT   = 2;

    logic          clk_100MHz;
    logic          reset_n;
    logic          mem_init;
    logic          p_req, p_we, h_req, h_we;
    logic [AW-1:0] p_addr, h_addr;
    logic [31:0]   p_wdata, h_wdata;
    logic          p_gnt, p_rvalid, p_err, h_gnt, h_rvalid, h_err;
    logic [31:0]   p_rdata, h_rdata;
    logic [AW-1:0] sm_writeAddr, sm_readAddr;
    logic [31:0]   sm_writeData, sm_readData;
    logic          sm_writeEn, sm_readEn, stall_pipe;
    logic [1:0]    dbg_state;

    sm_port_arbiter #(.SM_DEPTH(SM_DEPTH), .ADDR_W(AW)) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .mem_init(mem_init),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_err(p_err),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
        .sm_writeAddr(sm_writeAddr), .sm_writeData(sm_writeData), .sm_writeEn(sm_writeEn),
        .sm_readAddr(sm_readAddr), .sm_readEn(sm_readEn), .sm_readData(sm_readData),
        .stall_pipe(stall_pipe), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    // ---------------- system memory environment ----------------
    logic [31:0] sys_mem [256];
    logic [31:0] ref_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            sys_mem[i] = v;
            ref_mem[i] = v;
        end
    end

    always @(posedge clk_100MHz) begin
        if (sm_writeEn) sys_mem[sm_writeAddr[AW-1:2]] <= sm_writeData;
        if (sm_readEn) sm_readData <= sys_mem[sm_readAddr[AW-1:2]];
    end

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic        owner_h;
        logic [31:0] data;
    } rsp_t;
    typedef struct {
        int   due;
        logic owner_h;
    } err_t;

    rsp_t        exp_q[$];
    err_t        err_q[$];
    int          mode = M_RUN;
    logic        last_h = 1'b1;
    logic [31:0] exp_p_rdata = 32'd0;
    logic [31:0] exp_h_rdata = 32'd0;

    task automatic model_reset();
        exp_q.delete();
        err_q.delete();
        mode        = M_RUN;
        last_h      = 1'b1;
        exp_p_rdata = 32'd0;
        exp_h_rdata = 32'd0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_p_gnt", 32'(p_gnt), 32'd0);
        chk("rst_h_gnt", 32'(h_gnt), 32'd0);
        chk("rst_wen", 32'(sm_writeEn), 32'd0);
        chk("rst_ren", 32'(sm_readEn), 32'd0);
        chk("rst_waddr", 32'(sm_writeAddr), 32'd0);
        chk("rst_wdata", sm_writeData, 32'd0);
        chk("rst_raddr", 32'(sm_readAddr), 32'd0);
        chk("rst_p_rvalid", 32'(p_rvalid), 32'd0);
        chk("rst_h_rvalid", 32'(h_rvalid), 32'd0);
        chk("rst_p_rdata", p_rdata, 32'd0);
        chk("rst_h_rdata", h_rdata, 32'd0);
        chk("rst_p_err", 32'(p_err), 32'd0);
        chk("rst_h_err", 32'(h_err), 32'd0);
        chk("rst_stall", 32'(stall_pipe), 32'd0);
    endtask

    task automatic model_step();
        logic          eg_p, eg_h, g, we, bad, pend;
        logic          ep_err, eh_err, ep_rv, eh_rv;
        logic [AW-1:0] a;
        logic [31:0]   wd;
        rsp_t          r;
        err_t          e;

        // responses and error pulses due this cycle
        ep_err = 1'b0;
        eh_err = 1'b0;
        while (err_q.size() > 0 && err_q[0].due == cyc) begin
            if (err_q[0].owner_h) eh_err = 1'b1;
            else ep_err = 1'b1;
            err_q.delete(0);
        end
        ep_rv = 1'b0;
        eh_rv = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].owner_h) begin
                eh_rv = 1'b1;
                exp_h_rdata = exp_q[0].data;
            end else begin
                ep_rv = 1'b1;
                exp_p_rdata = exp_q[0].data;
            end
            exp_q.delete(0);
        end

        // who owns memory this cycle
        eg_p = 1'b0;
        eg_h = 1'b0;
        if (mode == M_RUN) begin
            if (p_req && h_req) begin
                eg_p = last_h;
                eg_h = !last_h;
            end else begin
                eg_p = p_req;
                eg_h = h_req;
            end
        end else if (mode == M_INIT) begin
            eg_h = h_req;
        end
        g   = eg_p || eg_h;
        we  = eg_h ? h_we : p_we;
        a   = eg_h ? h_addr : p_addr;
        wd  = eg_h ? h_wdata : p_wdata;
        bad = (a[1:0] != 2'b00) || ((int'(a) / 4) >= SM_DEPTH);

        chk("p_gnt", 32'(p_gnt), 32'(eg_p));
        chk("h_gnt", 32'(h_gnt), 32'(eg_h));
        chk("sm_writeEn", 32'(sm_writeEn), 32'(g && we && !bad));
        if (g && we && !bad) begin
            chk("sm_writeAddr", 32'(sm_writeAddr), 32'(a));
            chk("sm_writeData", sm_writeData, wd);
        end
        chk("sm_readEn", 32'(sm_readEn), 32'(g && !we && !bad));
        if (g && !we && !bad) chk("sm_readAddr", 32'(sm_readAddr), 32'(a));
        chk("p_err", 32'(p_err), 32'(ep_err));
        chk("h_err", 32'(h_err), 32'(eh_err));
        chk("p_rvalid", 32'(p_rvalid), 32'(ep_rv));
        chk("h_rvalid", 32'(h_rvalid), 32'(eh_rv));
        chk("p_rdata", p_rdata, exp_p_rdata);
        chk("h_rdata", h_rdata, exp_h_rdata);
        chk("stall_pipe", 32'(stall_pipe), 32'(mode != M_RUN));
        chk("state_legal", 32'(dbg_state != 2'd3), 32'd1);

        // consequences of this cycle's grant
        if (g && bad) begin
            e.due     = cyc + 1;
            e.owner_h = eg_h;
            err_q.push_back(e);
        end
        if (g && !we) begin
            r.due     = cyc + 2;
            r.owner_h = eg_h;
            r.data    = bad ? 32'd0 : ref_mem[int'(a) / 4];
            exp_q.push_back(r);
        end
        if (g && we && !bad) ref_mem[int'(a) / 4] = wd;
        if (g) last_h = eg_h;

        // is a read still waiting for a memory data cycle after this edge?
        pend = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].due > cyc + 1) pend = 1'b1;
        case (mode)
            M_RUN:   if (mem_init) mode = pend ? M_DRAIN : M_INIT;
            M_DRAIN: if (!pend) mode = mem_init ? M_INIT : M_RUN;
            default: if (!mem_init) mode = M_RUN;
        endcase
    endtask

    // ---------------- compare process ----------------
    initial begin
        @(posedge clk_100MHz);
        forever begin
            @(negedge clk_100MHz);
            if (!reset_n) begin
                check_reset_outputs();
                model_reset();
            end else begin
                model_step();
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic set_p(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        p_req = req; p_we = we; p_addr = a; p_wdata = d;
    endtask

    task automatic set_h(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        h_req = req; h_we = we; h_addr = a; h_wdata = d;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return AW'(($urandom_range(0, 127) << 2) | $urandom_range(1, 3));
        if (r == 1) return AW'($urandom_range(128, 255) << 2);
        return AW'($urandom_range(0, 15) << 2);
    endfunction

    // ---------------- stimulus ----------------
    logic [31:0] dw [4];
    logic        pg, hg;

    initial begin
        reset_n  = 1'b0;
        mem_init = 1'b0;
        set_p(1'b0, 1'b0, '0, '0);
        set_h(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) dw[i] = $urandom;
        repeat (3) @(posedge clk_100MHz);
        #1 reset_n = 1'b1;

        // pipeline write then read of 0x010
        set_p(1'b1, 1'b1, 10'h010, 32'hDEADBEEF);
        @(negedge clk_100MHz);
        chk("t1_wr_gnt", 32'(p_gnt), 32'd1);
        chk("t1_wen", 32'(sm_writeEn), 32'd1);
        chk("t1_waddr", 32'(sm_writeAddr), 32'h010);
        tick();
        set_p(1'b1, 1'b0, 10'h010, 32'd0);
        @(negedge clk_100MHz);
        chk("t1_rd_gnt", 32'(p_gnt), 32'd1);
        chk("t1_ren", 32'(sm_readEn), 32'd1);
        chk("t1_wen_once", 32'(sm_writeEn), 32'd0);
        tick();
        set_p(1'b0, 1'b0, '0, '0);
        @(negedge clk_100MHz);
        chk("t1_rvalid_n1", 32'(p_rvalid), 32'd0);
        tick();
        @(negedge clk_100MHz);
        chk("t1_rvalid_n2", 32'(p_rvalid), 32'd1);
        chk("t1_rdata", p_rdata, 32'hDEADBEEF);
        tick();

        // read in flight, then asynchronous reset for one cycle
        set_p(1'b1, 1'b0, 10'h010, 32'd0);
        @(negedge clk_100MHz);
        chk("t6_gnt", 32'(p_gnt), 32'd1);
        tick();
        set_h(1'b1, 1'b0, 10'h020, 32'd0);
        #1 reset_n = 1'b0;
        @(negedge clk_100MHz);
        chk("t6_no_p_gnt", 32'(p_gnt), 32'd0);
        chk("t6_no_h_gnt", 32'(h_gnt), 32'd0);
        chk("t6_rvalid", 32'(p_rvalid), 32'd0);
        tick();
        reset_n = 1'b1;

        // contention straight after reset: P, H, P, H
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_100MHz);
            chk("t2_p_gnt", 32'(p_gnt), 32'(i % 2 == 0));
            chk("t2_h_gnt", 32'(h_gnt), 32'(i % 2 == 1));
            if (i < 2) chk("t2_no_stale_rvalid", 32'(p_rvalid), 32'd0);
            if (i == 2) begin
                chk("t2_p_rvalid", 32'(p_rvalid), 32'd1);
                chk("t2_p_rdata", p_rdata, 32'hDEADBEEF);
            end
            tick();
        end
        set_p(1'b0, 1'b0, '0, '0);
        set_h(1'b0, 1'b0, '0, '0);
        @(negedge clk_100MHz);
        chk("t2_p_rvalid_last", 32'(p_rvalid), 32'd1);
        tick();
        tick();

        // init entry with a P read granted in the same cycle
        set_p(1'b1, 1'b0, 10'h010, 32'd0);
        mem_init = 1'b1;
        @(negedge clk_100MHz);
        chk("t3_gnt", 32'(p_gnt), 32'd1);
        chk("t3_stall_n", 32'(stall_pipe), 32'd0);
        tick();
        set_p(1'b1, 1'b0, 10'h008, 32'd0);
        set_h(1'b1, 1'b1, 10'h000, dw[0]);
        @(negedge clk_100MHz);
        chk("t3_drain_stall", 32'(stall_pipe), 32'd1);
        chk("t3_drain_p_gnt", 32'(p_gnt), 32'd0);
        chk("t3_drain_h_gnt", 32'(h_gnt), 32'd0);
        tick();
        @(negedge clk_100MHz);
        chk("t3_rvalid", 32'(p_rvalid), 32'd1);
        chk("t3_rdata", p_rdata, 32'hDEADBEEF);
        chk("t3_init_h_gnt", 32'(h_gnt), 32'd1);
        chk("t3_init_p_gnt", 32'(p_gnt), 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            set_h(1'b1, 1'b1, AW'(i * 4), dw[i]);
            @(negedge clk_100MHz);
            chk("t4_h_gnt", 32'(h_gnt), 32'd1);
            chk("t4_p_gnt", 32'(p_gnt), 32'd0);
            chk("t4_wen", 32'(sm_writeEn), 32'd1);
        end
        tick();
        set_h(1'b0, 1'b0, '0, '0);
        mem_init = 1'b0;
        @(negedge clk_100MHz);
        chk("t4_still_init", 32'(stall_pipe), 32'd1);
        tick();
        @(negedge clk_100MHz);
        chk("t4_run_stall", 32'(stall_pipe), 32'd0);
        chk("t4_run_p_gnt", 32'(p_gnt), 32'd1);
        tick();
        set_p(1'b0, 1'b0, '0, '0);
        @(negedge clk_100MHz);
        tick();
        @(negedge clk_100MHz);
        chk("t4_rvalid", 32'(p_rvalid), 32'd1);
        chk("t4_rdata", p_rdata, dw[2]);
        tick();

        // bad addresses
        set_p(1'b1, 1'b0, 10'h012, 32'd0);
        @(negedge clk_100MHz);
        chk("t5_p_gnt", 32'(p_gnt), 32'd1);
        chk("t5_no_ren", 32'(sm_readEn), 32'd0);
        tick();
        set_p(1'b0, 1'b0, '0, '0);
        set_h(1'b1, 1'b1, 10'h200, 32'h12345678);
        @(negedge clk_100MHz);
        chk("t5_p_err", 32'(p_err), 32'd1);
        chk("t5_h_gnt", 32'(h_gnt), 32'd1);
        chk("t5_no_wen", 32'(sm_writeEn), 32'd0);
        tick();
        set_h(1'b0, 1'b0, '0, '0);
        @(negedge clk_100MHz);
        chk("t5_h_err", 32'(h_err), 32'd1);
        chk("t5_p_rvalid", 32'(p_rvalid), 32'd1);
        chk("t5_p_rdata", p_rdata, 32'd0);
        tick();

        // random traffic; requests stay stable until granted
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk_100MHz);
            pg = p_gnt;
            hg = h_gnt;
            tick();
            if (!p_req || pg) begin
                if ($urandom_range(0, 9) < 6) set_p(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                else set_p(1'b0, 1'b0, '0, '0);
            end
            if (!h_req || hg) begin
                if ($urandom_range(0, 9) < 5) set_h(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                else set_h(1'b0, 1'b0, '0, '0);
            end
            if ($urandom_range(0, 39) == 0) mem_init = !mem_init;
        end

        // settle: wait out any pending grant before dropping requests
        mem_init = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_100MHz);
            pg = p_gnt;
            hg = h_gnt;
            tick();
            if (pg) set_p(1'b0, 1'b0, '0, '0);
            if (hg) set_h(1'b0, 1'b0, '0, '0);
        end
        set_p(1'b0, 1'b0, '0, '0);
        set_h(1'b0, 1'b0, '0, '0);
        repeat (4) tick();
        @(negedge clk_100MHz);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
